// File: rtl/spi_adc_responder_pkg.sv
// Shared constants, FSM state type and sample-selection helper for the
// two-channel SPI ADC responder.
package spi_adc_responder_pkg;

  localparam int CMD_W            = 8;
  localparam int DATA_W           = 12;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int CNT_W            = 5;

  localparam logic [CMD_W-1:0] CMD_CH0 = 8'b1001_0111;
  localparam logic [CMD_W-1:0] CMD_CH1 = 8'b1101_0111;

  localparam int CMD_START_BIT = 7;
  localparam int CMD_CH_BIT    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  // A command without its start bit reads back as all zeros.
  function automatic logic [DATA_W-1:0] select_sample(
    input logic              start,
    input logic              ch_sel,
    input logic [DATA_W-1:0] ch0,
    input logic [DATA_W-1:0] ch1
  );
    if (!start) return '0;
    return ch_sel ? ch1 : ch0;
  endfunction

endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI link bundle between the master and the ADC responder.
interface spi_adc_responder_if;
  logic cs;
  logic dclk;
  logic mosi;
  logic miso;

  modport master (output cs, output dclk, output mosi, input miso);
  modport slave  (input cs, input dclk, input mosi, output miso);
endinterface

// File: rtl/spi_adc_responder_sync_edge.sv
// Multi-flop synchronizer with an edge register; rise/fall are the XOR of the
// last two synchronized samples, qualified by the current level.
module spi_adc_responder_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              toggled;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level   = sync_q[STAGES-1];
  assign toggled = level ^ prev_q;
  assign rise    = toggled & level;
  assign fall    = toggled & ~level;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a two-channel 12-bit ADC; all SPI lines are
// oversampled in the clk_i domain and dclk is never used as a clock.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spi_adc_responder_if.slave spi,
  input  logic [DATA_W-1:0] ch0_data_i,
  input  logic [DATA_W-1:0] ch1_data_i,
  output logic [CMD_W-1:0]  cmd_o,
  output logic              cmd_valid_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(CMD_W + DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(CMD_W + DATA_W);

  logic cs_lvl, cs_rise, cs_fall;
  logic dclk_lvl, dclk_rise, dclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_adc_responder_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk_i), .rst(rst_i), .din(spi.cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_adc_responder_sync_edge #(.STAGES(SYNC_STAGES)) u_dclk_sync (
    .clk(clk_i), .rst(rst_i), .din(spi.dclk),
    .level(dclk_lvl), .rise(dclk_rise), .fall(dclk_fall)
  );

  spi_adc_responder_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk_i), .rst(rst_i), .din(spi.mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CMD_W-2:0]  cmd_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [CMD_W-1:0]  cmd_next;
  logic              unused_levels;

  assign cmd_next      = {cmd_sr, mosi_lvl};
  assign unused_levels = cs_lvl ^ dclk_lvl;

  // cs rise outranks any dclk edge in the same cycle; a rise before DONE is an aborted frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      tx_sr       <= '0;
      spi.miso    <= 1'b0;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (cs_rise && (state == ST_CMD || state == ST_DATA)) begin
        frame_err_o <= 1'b1;
        state       <= ST_IDLE;
        spi.miso    <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            spi.miso <= 1'b0;
            busy_o   <= 1'b0;
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
              cmd_sr  <= '0;
              busy_o  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (dclk_rise) begin
              cmd_sr  <= cmd_next[CMD_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_CMD_LAST) begin
                cmd_o       <= cmd_next;
                cmd_valid_o <= 1'b1;
                tx_sr       <= select_sample(cmd_next[CMD_START_BIT], cmd_next[CMD_CH_BIT],
                                             ch0_data_i, ch1_data_i);
                state       <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (dclk_fall) begin
              spi.miso <= tx_sr[DATA_W-1];
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (dclk_rise) begin
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_FRAME_LAST) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            spi.miso <= 1'b0;
            if (cs_rise) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: drives the master side of the
// link with slow (40-cycle half period) dclk and compares against a read model.
module tb_spi_adc_responder;
  import spi_adc_responder_pkg::*;

  localparam int HALF = 40;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] ch0_data_i = '0;
  logic [11:0] ch1_data_i = '0;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o;
  logic        busy_o;
  logic        frame_err_o;

  int compared   = 0;
  int mismatched = 0;
  int valid_pulses = 0;
  int err_pulses   = 0;
  logic [7:0]  model_cmd = '0;
  logic [11:0] exp_data;

  spi_adc_responder_if spi();

  spi_adc_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .spi         (spi),
    .ch0_data_i  (ch0_data_i),
    .ch1_data_i  (ch1_data_i),
    .cmd_o       (cmd_o),
    .cmd_valid_o (cmd_valid_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (cmd_valid_o) valid_pulses++;
    if (frame_err_o) err_pulses++;
  end

  // What an ideal ADC returns for a command, from the command map alone.
  function automatic logic [11:0] refResponse(input logic [7:0] cmd,
                                              input logic [11:0] c0,
                                              input logic [11:0] c1);
    int code;
    code = int'(cmd);
    if (code < 128) return 12'h000;
    return (((code / 64) % 2) == 1) ? c1 : c0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"},  32'(spi.miso),    32'd0);
    checkOutput({tag, "_cmd"},   32'(cmd_o),       32'd0);
    checkOutput({tag, "_valid"}, 32'(cmd_valid_o), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy_o),      32'd0);
    checkOutput({tag, "_err"},   32'(frame_err_o), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int n_rises, input int rst_at,
                               input bit chg_en, input logic [11:0] chg_val,
                               output logic [11:0] rd);
    rd = '0;
    waitCycles($urandom_range(5, 40));
    valid_pulses = 0;
    err_pulses   = 0;
    spi.cs = 1'b0;
    for (int i = 1; i <= n_rises; i++) begin
      spi.mosi = (i <= 8) ? cmd[8-i] : 1'b0;
      waitCycles(HALF);
      if (i > 8) rd = {rd[10:0], spi.miso};
      spi.dclk = 1'b1;
      waitCycles(HALF / 2);
      if (i == 4) checkOutput("busy_mid", 32'(busy_o), 32'd1);
      if (chg_en && i == 8) ch0_data_i = chg_val;
      if (i == rst_at) begin
        rst_i = 1'b1;
        waitCycles(1);
        rst_i = 1'b0;
        checkResetOutputs("midrst");
        valid_pulses = 0;
        err_pulses   = 0;
      end
      waitCycles(HALF - HALF / 2);
      spi.dclk = 1'b0;
    end
    waitCycles(HALF);
    spi.cs   = 1'b1;
    spi.mosi = 1'b0;
    waitCycles(10);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] cmd, input int n_rises,
                          input int rst_at, input bit chg_en, input logic [11:0] chg_val,
                          input logic [11:0] expected);
    logic [11:0] rd;
    applyStimulus(cmd, n_rises, rst_at, chg_en, chg_val, rd);
    if (rst_at > 0) begin
      model_cmd = '0;
      checkOutput({tag, "_valid_after_rst"}, 32'(valid_pulses), 32'd0);
      checkOutput({tag, "_err_after_rst"},   32'(err_pulses),   32'd0);
    end else if (n_rises < 20) begin
      checkOutput({tag, "_valid_cnt"}, 32'(valid_pulses), 32'(n_rises >= 8));
      checkOutput({tag, "_err_cnt"},   32'(err_pulses),   32'd1);
    end else begin
      model_cmd = cmd;
      checkOutput({tag, "_valid_cnt"}, 32'(valid_pulses), 32'd1);
      checkOutput({tag, "_err_cnt"},   32'(err_pulses),   32'd0);
      checkOutput({tag, "_data"},      32'(rd),           32'(expected));
    end
    checkOutput({tag, "_cmd"},        32'(cmd_o),    32'(model_cmd));
    checkOutput({tag, "_busy_after"}, 32'(busy_o),   32'd0);
    checkOutput({tag, "_miso_after"}, 32'(spi.miso), 32'd0);
  endtask

  initial begin
    logic [7:0] rcmd;
    spi.cs   = 1'b1;
    spi.dclk = 1'b0;
    spi.mosi = 1'b0;
    waitCycles(6);
    checkResetOutputs("reset");
    rst_i = 1'b0;
    waitCycles(10);

    ch0_data_i = 12'hA5C;
    ch1_data_i = 12'h123;
    runFrame("ch0_read", CMD_CH0, 20, 0, 1'b0, 12'h000, 12'hA5C);
    runFrame("ch1_read", CMD_CH1, 20, 0, 1'b0, 12'h000, 12'h123);
    runFrame("no_start", 8'b0001_0111, 20, 0, 1'b0, 12'h000,
             refResponse(8'b0001_0111, ch0_data_i, ch1_data_i));

    runFrame("abort", CMD_CH0, 5, 0, 1'b0, 12'h000, 12'h000);
    runFrame("post_abort", CMD_CH0, 20, 0, 1'b0, 12'h000, 12'hA5C);

    ch0_data_i = 12'hFFF;
    runFrame("data_change", CMD_CH0, 20, 0, 1'b1, 12'h000, 12'hFFF);

    ch0_data_i = 12'h3C6;
    runFrame("mid_reset", CMD_CH1, 20, 12, 1'b0, 12'h000, 12'h000);
    runFrame("post_reset", CMD_CH1, 20, 0, 1'b0, 12'h000, 12'h123);

    for (int n = 0; n < 6; n++) begin
      rcmd       = 8'($urandom_range(0, 255));
      ch0_data_i = 12'($urandom);
      ch1_data_i = 12'($urandom);
      exp_data   = refResponse(rcmd, ch0_data_i, ch1_data_i);
      runFrame("random", rcmd, 20, 0, 1'b0, 12'h000, exp_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
